// File: rtl/sm_reg_dump_uart_pkg.sv
// Shared types and constants for the register-dump UART initiator.
// The package holds the dump FSM encoding, the ASCII constants and the line length.
package sm_reg_dump_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_SEND,
      ST_NEXT
   } dump_state_t;

   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_A     = 8'h41;
   localparam int         LINE_LEN  = 13;

   // Maps a nibble to its uppercase ASCII hex digit.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (ASC_0 + {4'h0, nib}) : (ASC_A + {4'h0, nib} - 8'd10);
   endfunction

endpackage

// File: rtl/sm_reg_dump_uart_if.sv
// Readout-port and UART bundle between the dump engine and the CPU/host side.
// The master modport is the dump engine; the slave modport is the CPU readout port and host.
interface sm_reg_dump_uart_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        tx;
   logic [4:0]  regAddr;
   logic [31:0] regData;

   modport master (
      input  start,
      input  regData,
      output busy,
      output done,
      output regAddr,
      output tx
   );

   modport slave (
      output start,
      output regData,
      input  busy,
      input  done,
      input  regAddr,
      input  tx
   );
endinterface

// File: rtl/sm_reg_dump_uart_tx.sv
// 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit.
// Ready rises in the last stop-bit cycle so back-to-back bytes leave no idle gap.
module sm_uart_tx #(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

   logic        r_active;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic [8:0]  r_shift;
   logic        r_tx;
   logic        w_bit_end;
   logic        w_accept;

   assign w_bit_end = (r_cnt == 16'd0);
   assign ready     = !r_active || (w_bit_end && (r_bit == 4'd9));
   assign w_accept  = valid && ready;
   assign tx        = r_tx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_cnt    <= 16'd0;
         r_bit    <= 4'd0;
         r_shift  <= '1;
         r_tx     <= 1'b1;
      end else if (w_accept) begin
         r_active <= 1'b1;
         r_cnt    <= BIT_LAST;
         r_bit    <= 4'd0;
         r_shift  <= {1'b1, data};
         r_tx     <= 1'b0;
      end else if (r_active) begin
         if (!w_bit_end) begin
            r_cnt <= r_cnt - 16'd1;
         end else if (r_bit == 4'd9) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
         end else begin
            // Shift in ones so the stop bit falls out after the eighth data bit.
            r_cnt   <= BIT_LAST;
            r_bit   <= r_bit + 4'd1;
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[8:1]};
         end
      end
   end

endmodule

// File: rtl/sm_reg_dump_uart.sv
// Register-dump initiator: walks regAddr over REG_FIRST..REG_LAST and prints
// each value as "AA:DDDDDDDD\r\n" on the UART line.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | waiting for start, regAddr parked at REG_FIRST
//   ST_SETTLE  | regAddr driven, waiting SETTLE cycles for regData
//   ST_CAPTURE | latch regData into the shadow register
//   ST_SEND    | feed the 13 line bytes, then wait for the UART to drain
//   ST_NEXT    | advance regAddr or finish the dump
module sm_reg_dump_uart
   import sm_reg_dump_uart_pkg::*;
#(
   parameter int CLK_DIV   = 434,
   parameter int SETTLE    = 4,
   parameter int REG_FIRST = 0,
   parameter int REG_LAST  = 31
) (
   input  logic                clk,
   input  logic                rst,
   sm_reg_dump_uart_if.master  bus
);

   localparam logic [4:0] ADDR_FIRST  = 5'(REG_FIRST);
   localparam logic [4:0] ADDR_LAST   = 5'(REG_LAST);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [3:0] LEN         = 4'(LINE_LEN);

   dump_state_t r_state;
   dump_state_t w_state_nxt;
   logic [7:0]  r_settle_cnt;
   logic [31:0] r_shadow;
   logic [3:0]  r_idx;
   logic [4:0]  r_addr;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  w_byte;
   logic [2:0]  w_nib_sel;
   logic        w_valid;
   logic        w_ready;
   logic        w_tx;

   always_comb begin
      w_state_nxt = r_state;
      w_valid     = 1'b0;
      case (r_state)
         ST_IDLE:    if (bus.start) w_state_nxt = ST_SETTLE;
         ST_SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = ST_SEND;
         ST_SEND: begin
            w_valid = (r_idx != LEN);
            if ((r_idx == LEN) && w_ready) w_state_nxt = ST_NEXT;
         end
         ST_NEXT:    w_state_nxt = (r_addr == ADDR_LAST) ? ST_IDLE : ST_SETTLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Character indices 3..10 select shadow nibbles 7..0.
   always_comb begin
      w_nib_sel = 3'(4'd10 - r_idx);
      w_byte    = ASC_LF;
      case (r_idx)
         4'd0:    w_byte = hex_ascii({3'b000, r_addr[4]});
         4'd1:    w_byte = hex_ascii(r_addr[3:0]);
         4'd2:    w_byte = ASC_COLON;
         4'd11:   w_byte = ASC_CR;
         4'd12:   w_byte = ASC_LF;
         default: w_byte = hex_ascii(r_shadow[{w_nib_sel, 2'b00} +: 4]);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 8'd0;
         r_shadow     <= 32'd0;
         r_idx        <= 4'd0;
         r_addr       <= ADDR_FIRST;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_done       <= (r_state == ST_NEXT) && (r_addr == ADDR_LAST);
         r_settle_cnt <= ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) ?
                         r_settle_cnt + 8'd1 : 8'd0;
         if (r_state == ST_CAPTURE) begin
            r_shadow <= bus.regData;
            r_idx    <= 4'd0;
         end else if (w_valid && w_ready) begin
            r_idx <= r_idx + 4'd1;
         end
         if (r_state == ST_NEXT) begin
            r_addr <= (r_addr == ADDR_LAST) ? ADDR_FIRST : r_addr + 5'd1;
         end
      end
   end

   sm_uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
      .clk   (clk),
      .rst   (rst),
      .data  (w_byte),
      .valid (w_valid),
      .ready (w_ready),
      .tx    (w_tx)
   );

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.regAddr = r_addr;
   assign bus.tx      = w_tx;

endmodule

// File: tb/tb_sm_reg_dump_uart.sv
// Directed bench: standalone UART frame, single-register dump, full 32-register
// dump with capture isolation and ignored starts, and reset during a frame.
module tb_sm_reg_dump_uart;

   localparam int CD = 4;

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] t_data;
   logic       t_valid;
   logic       t_ready;
   logic       t_tx;

   sm_uart_tx #(.CLK_DIV(CD)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .data  (t_data),
      .valid (t_valid),
      .ready (t_ready),
      .tx    (t_tx)
   );

   sm_reg_dump_uart_if if_one ();
   sm_reg_dump_uart_if if_full ();

   sm_reg_dump_uart #(.CLK_DIV(CD), .SETTLE(2), .REG_FIRST(3), .REG_LAST(3)) u_one (
      .clk (clk),
      .rst (rst),
      .bus (if_one.master)
   );

   sm_reg_dump_uart #(.CLK_DIV(CD), .SETTLE(2), .REG_FIRST(0), .REG_LAST(31)) u_full (
      .clk (clk),
      .rst (rst),
      .bus (if_full.master)
   );

   logic        ovr_en;
   logic [31:0] ovr_val;
   assign if_full.regData = ovr_en ? ovr_val : (32'h100 + {27'h0, if_full.regAddr});

   int n_asrt = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int busy_one = 0, done_one = 0, busy_full = 0, done_full = 0;
   always @(negedge clk) begin
      if (if_one.busy === 1'b1)  busy_one  <= busy_one + 1;
      if (if_one.done === 1'b1)  done_one  <= done_one + 1;
      if (if_full.busy === 1'b1) busy_full <= busy_full + 1;
      if (if_full.done === 1'b1) done_full <= done_full + 1;
   end

   // Receiver: entered on the first start-bit sample, samples bit centres, aborts on reset.
   task automatic rx_byte(input bit sel, output logic [7:0] b, output bit ok, output bit ferr);
      logic s;
      b = 8'h00; ok = 1'b1; ferr = 1'b0;
      for (int i = 1; i <= 38; i++) begin
         @(negedge clk);
         if (rst) begin
            ok = 1'b0;
            return;
         end
         s = sel ? if_full.tx : if_one.tx;
         if (i == 2 && s !== 1'b0) ferr = 1'b1;
         if (i >= 6 && i <= 34 && (i % 4) == 2) b[(i - 6) / 4] = s;
         if (i == 38 && s !== 1'b1) ferr = 1'b1;
      end
   endtask

   logic [7:0] q_one[$];
   logic [7:0] q_full[$];
   int fe_one = 0, fe_full = 0;
   logic [7:0] rb_one, rb_full;
   bit ok_one, ok_full, er_one, er_full;

   always begin
      @(negedge clk);
      if (if_one.tx === 1'b0 && rst === 1'b0) begin
         rx_byte(1'b0, rb_one, ok_one, er_one);
         if (ok_one) begin
            q_one.push_back(rb_one);
            if (er_one) fe_one = fe_one + 1;
         end
      end
   end

   always begin
      @(negedge clk);
      if (if_full.tx === 1'b0 && rst === 1'b0) begin
         rx_byte(1'b1, rb_full, ok_full, er_full);
         if (ok_full) begin
            q_full.push_back(rb_full);
            if (er_full) fe_full = fe_full + 1;
         end
      end
   end

   logic [79:0]  got_f, exp_f;
   logic [9:0]   fa, fb;
   int           rdy_lo;
   logic         rdy39;
   int           b_busy, b_done, b_q;
   logic [103:0] gl, el;
   logic [7:0]   e[13];
   string        hx;
   logic         tx_hi;

   initial begin
      hx = "0123456789ABCDEF";
      rst = 1'b1;
      t_data = 8'h00; t_valid = 1'b0;
      if_one.start = 1'b0; if_one.regData = 32'h1234ABCD;
      if_full.start = 1'b0;
      ovr_en = 1'b0; ovr_val = 32'hDEADBEEF;

      // Reset state after the first reset edge
      @(posedge clk);
      @(negedge clk);
      check("rst_one_tx", if_one.tx, 1);
      check("rst_one_busy", if_one.busy, 0);
      check("rst_one_done", if_one.done, 0);
      check("rst_one_addr", if_one.regAddr, 3);
      check("rst_full_tx", if_full.tx, 1);
      check("rst_full_busy", if_full.busy, 0);
      check("rst_full_addr", if_full.regAddr, 0);
      check("rst_uart_ready", t_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("idle_no_bytes", q_one.size() + q_full.size(), 0);
      check("idle_full_tx", if_full.tx, 1);

      // Standalone UART: 0xA5 then 0x3C back to back
      t_data = 8'hA5; t_valid = 1'b1;
      rdy_lo = 0; rdy39 = 1'b0; got_f = '0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         got_f[k] = t_tx;
         if (k < 40 && t_ready == 1'b0) rdy_lo++;
         if (k == 39) rdy39 = t_ready;
         if (k == 0) t_data = 8'h3C;
         if (k == 40) t_valid = 1'b0;
      end
      fa = {1'b1, 8'hA5, 1'b0};
      fb = {1'b1, 8'h3C, 1'b0};
      for (int k = 0; k < 80; k++) exp_f[k] = (k < 40) ? fa[k / 4] : fb[(k - 40) / 4];
      check("uart_frame_a5", got_f[39:0], exp_f[39:0]);
      check("uart_frame_3c_no_gap", got_f[79:40], exp_f[79:40]);
      check("uart_ready_low_cycles", rdy_lo, 39);
      check("uart_ready_last_stop", rdy39, 1);
      @(negedge clk);
      check("uart_idle_after", {t_ready, t_tx}, 2'b11);

      // One-register dump with starts injected mid-dump and during NEXT
      b_busy = busy_one; b_done = done_one; b_q = q_one.size();
      if_one.start = 1'b1;
      for (int k = 0; k < 560; k++) begin
         @(negedge clk);
         if_one.start = (k == 99 || k == 524);
         if (k == 524) check("one_busy_in_next", {if_one.busy, if_one.done}, 2'b10);
         if (k == 525) check("one_done_pulse", {if_one.busy, if_one.done}, 2'b01);
      end
      if_one.start = 1'b0;
      @(negedge clk);
      gl = '0;
      for (int j = 0; j < 13; j++) gl[8 * (12 - j) +: 8] = q_one[b_q + j];
      check("one_line", gl, 104'h30333A31323334414243440D0A);
      check("one_byte_count", q_one.size() - b_q, 13);
      check("one_done_count", done_one - b_done, 1);
      check("one_busy_cycles", busy_one - b_busy, 525);
      check("one_addr_end", if_one.regAddr, 3);
      check("one_framing", fe_one, 0);

      // Full dump: regData perturbed after reg 0 capture and through reg 1 settle
      b_busy = busy_full; b_done = done_full; b_q = q_full.size();
      if_full.start = 1'b1;
      for (int k = 0; k < 16820; k++) begin
         @(negedge clk);
         if_full.start = (k == 524 || k == 3000);
         if (k == 7)   ovr_en = 1'b1;
         if (k == 527) ovr_en = 1'b0;
      end
      if_full.start = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         e[0] = hx[k / 16]; e[1] = hx[k % 16]; e[2] = 8'h3A;
         for (int j = 3; j < 8; j++) e[j] = 8'h30;
         e[8] = 8'h31; e[9] = hx[k / 16]; e[10] = hx[k % 16];
         e[11] = 8'h0D; e[12] = 8'h0A;
         gl = '0; el = '0;
         for (int j = 0; j < 13; j++) begin
            gl[8 * (12 - j) +: 8] = q_full[b_q + 13 * k + j];
            el[8 * (12 - j) +: 8] = e[j];
         end
         check($sformatf("full_line_%0d", k), gl, el);
      end
      check("full_byte_count", q_full.size() - b_q, 416);
      check("full_done_count", done_full - b_done, 1);
      check("full_busy_cycles", busy_full - b_busy, 32 * 525);
      check("full_addr_end", if_full.regAddr, 0);
      check("full_framing", fe_full, 0);

      // Reset in the start bit of the first byte
      b_done = done_full; b_q = q_full.size();
      if_full.start = 1'b1;
      @(negedge clk);
      if_full.start = 1'b0;
      repeat (5) @(negedge clk);
      check("midframe_tx_low", if_full.tx, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midframe_rst_state", {if_full.tx, if_full.busy, if_full.done, if_full.regAddr},
            {1'b1, 1'b0, 1'b0, 5'd0});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tx_hi = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (if_full.tx !== 1'b1) tx_hi = 1'b0;
      end
      check("post_rst_tx_idle", tx_hi, 1);
      check("post_rst_no_done", done_full - b_done, 0);
      check("post_rst_no_bytes", q_full.size() - b_q, 0);
      check("post_rst_busy", if_full.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
